rto_core_param: RTL and testbench
=================================

// Module: rto_core_param
// PURPOSE
// - Parametrised real-time output core: buffers {timestamp,payload} words and releases each when the global counter equals its timestamp.
// - Next generation of the per-DAC RTO core: internal inferred FIFO (no vendor IP), configurable widths/depth, selectable late-event policy, saturating error counters, fill level.
// - Sits between the AXI command writer and the DAC sequencer, one instance per output channel.
// PARAMETERS
// - TS_WIDTH       64    timestamp/counter width (bits)
// - DATA_WIDTH     64    payload width (bits); word width W = TS_WIDTH+DATA_WIDTH, timestamp in MSBs
// - DEPTH          8192  FIFO entries, power of two, >= 4
// - FULL_THRESH    8100  fill level at which full asserts, 1..DEPTH
// - ERR_CNT_WIDTH  16    width of each error counter
// PORTS
// - clk                   in   1            system clock, all logic on rising edge
// - reset_n               in   1            asynchronous, active-low reset
// - auto_start            in   1            1 = release/compare enabled; 0 = FIFO holds head
// - flush                 in   1            synchronous FIFO clear
// - write                 in   1            push fifo_din this cycle
// - fifo_din              in   W            {timestamp, payload}
// - counter               in   TS_WIDTH     global time counter
// - late_mode             in   1            0 = drop late words, 1 = emit late words
// - error_clear           in   1            clear error counters
// - rto_out               out  W            last released word (held)
// - counter_matched       out  1            1-cycle pulse: rto_out updated
// - timestamp_error       out  1            1-cycle pulse: late head popped
// - timestamp_error_data  out  W            last late word
// - overflow_error        out  1            1-cycle pulse: write rejected
// - overflow_error_data   out  W            last rejected word
// - timestamp_error_count out  ERR_CNT_WIDTH saturating late-word count
// - overflow_error_count  out  ERR_CNT_WIDTH saturating rejected-write count
// - fill_level            out  log2(DEPTH)+1 entries stored
// - full                  out  1            fill_level >= FULL_THRESH
// - empty                 out  1            fill_level == 0
// BEHAVIOUR
// - reset_n low: FIFO pointers and fill_level 0, empty=1, full=0; all other outputs, data registers and counters 0.
// - FIFO is first-word-fall-through: word pushed into empty FIFO is at head and empty=0 on the next cycle.
// - head_ts = head[W-1:DATA_WIDTH]; compares are unsigned, no wrap handling (counter never wraps in a run).
// - match = auto_start & ~empty & (head_ts == counter): pop; next cycle rto_out = head, counter_matched = 1.
// - late = auto_start & ~empty & (counter > head_ts): pop; next cycle timestamp_error = 1, timestamp_error_data = head, count += 1 (sat).
//   - late_mode=0: rto_out unchanged, counter_matched = 0.
//   - late_mode=1: also rto_out = head, counter_matched = 1.
// - At most one pop per cycle; head_ts > counter or auto_start=0: no pop, no pulses.
// - write & ~full: push. write & full: word discarded; next cycle overflow_error = 1, overflow_error_data = fifo_din, count += 1 (sat).
// - Push and pop in same cycle: both occur, fill_level unchanged; push into empty FIFO is never popped the same cycle.
// - full/empty/fill_level are registered and reflect the state after the previous edge.
// - flush: next cycle fill_level = 0, empty = 1; write and pop in the flush cycle are ignored (no pulses, no count); rto_out, error data and counters retained.
// - error_clear: both counts = 0 next cycle; an increment in the same cycle is lost (clear wins).
// - Counters saturate at all-ones and stay until error_clear or reset.
// - Async reset mid-operation: immediate return to reset state, FIFO contents discarded.
// TESTING
// - Push ts=10,20,30 with counter=0, auto_start=1, step counter 0..40 -> counter_matched at counter=10,20,30 (+1 cycle), rto_out = each word, empty=1 after third.
// - Push ts=5 while counter=8, late_mode=0 -> timestamp_error pulse, count=1, rto_out unchanged; repeat with late_mode=1 -> rto_out = word, counter_matched=1.
// - DEPTH=16, FULL_THRESH=12: write 14 words, auto_start=0 -> 12 stored, full=1, overflow_error twice, overflow_error_data = word 14, count=2.
// - ERR_CNT_WIDTH=2: force 5 overflows -> overflow_error_count=3; error_clear -> 0 next cycle.
// - Fill 6 words, assert flush with simultaneous write -> fill_level=0, empty=1, no overflow, rto_out retained.
// - Drop reset_n mid-stream with 5 words queued -> all outputs 0 immediately, empty=1, no pulses after release until new writes.

Source files
------------

// File: rtl/rto_core_param.sv
// Real-time output core: queues {timestamp,payload} words and releases each one
// when the global counter reaches its timestamp, with late/overflow error tracking.

module rto_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (clr)
         count <= '0;  // clear wins over a same-cycle increment
      else if (inc && (count != {WIDTH{1'b1}}))
         count <= count + WIDTH'(1);
   end
endmodule

module rto_fifo #(
   parameter int W           = 128,
   parameter int DEPTH       = 8192,
   parameter int FULL_THRESH = 8100,
   parameter int AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic [AW:0]   fill_level,
   output logic          full,
   output logic          empty
);
   localparam logic [AW:0] THRESH = (AW+1)'(FULL_THRESH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level_nxt;

   // Storage carries no reset so it can map onto RAM; pointers define validity.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= din;
   end

   // First-word-fall-through: the head is always visible at the read pointer.
   assign head = mem[rd_ptr];

   always_comb begin
      level_nxt = fill_level;
      case ({push, pop})
         2'b10:   level_nxt = fill_level + (AW+1)'(1);
         2'b01:   level_nxt = fill_level - (AW+1)'(1);
         default: level_nxt = fill_level;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         fill_level <= level_nxt;
         empty      <= (level_nxt == '0);
         full       <= (level_nxt >= THRESH);
      end
   end
endmodule

module rto_core_param #(
   parameter int TS_WIDTH      = 64,
   parameter int DATA_WIDTH    = 64,
   parameter int DEPTH         = 8192,
   parameter int FULL_THRESH   = 8100,
   parameter int ERR_CNT_WIDTH = 16,
   parameter int W             = TS_WIDTH + DATA_WIDTH,
   parameter int AW            = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     auto_start,
   input  logic                     flush,
   input  logic                     write,
   input  logic [W-1:0]             fifo_din,
   input  logic [TS_WIDTH-1:0]      counter,
   input  logic                     late_mode,
   input  logic                     error_clear,
   output logic [W-1:0]             rto_out,
   output logic                     counter_matched,
   output logic                     timestamp_error,
   output logic [W-1:0]             timestamp_error_data,
   output logic                     overflow_error,
   output logic [W-1:0]             overflow_error_data,
   output logic [ERR_CNT_WIDTH-1:0] timestamp_error_count,
   output logic [ERR_CNT_WIDTH-1:0] overflow_error_count,
   output logic [AW:0]              fill_level,
   output logic                     full,
   output logic                     empty
);
   logic [W-1:0]        head;
   logic [TS_WIDTH-1:0] head_ts;
   logic                armed, match, late, pop, push, reject, emit;

   assign head_ts = head[W-1:DATA_WIDTH];

   // A flush cycle suppresses both pop and push so no pulse or count leaks out.
   assign armed  = auto_start & ~empty & ~flush;
   assign match  = armed & (head_ts == counter);
   assign late   = armed & (counter > head_ts);
   assign pop    = match | late;
   assign push   = write & ~full & ~flush;
   assign reject = write & full & ~flush;
   assign emit   = match | (late & late_mode);

   rto_fifo #(
      .W           (W),
      .DEPTH       (DEPTH),
      .FULL_THRESH (FULL_THRESH),
      .AW          (AW)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .push       (push),
      .pop        (pop),
      .din        (fifo_din),
      .head       (head),
      .fill_level (fill_level),
      .full       (full),
      .empty      (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rto_out              <= '0;
         counter_matched      <= 1'b0;
         timestamp_error      <= 1'b0;
         timestamp_error_data <= '0;
         overflow_error       <= 1'b0;
         overflow_error_data  <= '0;
      end else begin
         counter_matched <= emit;
         timestamp_error <= late;
         overflow_error  <= reject;
         if (emit)
            rto_out <= head;
         if (late)
            timestamp_error_data <= head;
         if (reject)
            overflow_error_data <= fifo_din;
      end
   end

   rto_sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_ts_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (late),
      .clr     (error_clear),
      .count   (timestamp_error_count)
   );

   rto_sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_ov_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (reject),
      .clr     (error_clear),
      .count   (overflow_error_count)
   );
endmodule

// File: tb/tb_rto_core_param.sv
// Bench for rto_core_param: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.

module tb_rto_core_param;
   localparam int TSW = 16, DW = 16, W = 32, DEPTH = 16, FT = 12, EW = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          auto_start = 1'b0, flush = 1'b0, write = 1'b0;
   logic [W-1:0]  fifo_din = '0;
   logic [TSW-1:0] counter = '0;
   logic          late_mode = 1'b0, error_clear = 1'b0;
   logic [W-1:0]  rto_out, timestamp_error_data, overflow_error_data;
   logic          counter_matched, timestamp_error, overflow_error, full, empty;
   logic [EW-1:0] timestamp_error_count, overflow_error_count;
   logic [4:0]    fill_level;

   int checks = 0, errors = 0, matched_seen = 0;

   rto_core_param #(
      .TS_WIDTH(TSW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
      .FULL_THRESH(FT), .ERR_CNT_WIDTH(EW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .auto_start(auto_start), .flush(flush),
      .write(write), .fifo_din(fifo_din), .counter(counter), .late_mode(late_mode),
      .error_clear(error_clear), .rto_out(rto_out), .counter_matched(counter_matched),
      .timestamp_error(timestamp_error), .timestamp_error_data(timestamp_error_data),
      .overflow_error(overflow_error), .overflow_error_data(overflow_error_data),
      .timestamp_error_count(timestamp_error_count),
      .overflow_error_count(overflow_error_count),
      .fill_level(fill_level), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of words and the rules for release/late/overflow.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_rto, m_ted, m_oed;
   logic         m_cm, m_te, m_oe;
   logic [EW-1:0] m_tec, m_oec;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_rto <= '0; m_ted <= '0; m_oed <= '0;
         m_cm <= 1'b0; m_te <= 1'b0; m_oe <= 1'b0;
         m_tec <= '0; m_oec <= '0;
      end else begin
         automatic int fl = mq.size();
         automatic logic is_late = 1'b0, is_rej = 1'b0, emit = 1'b0;
         automatic logic [W-1:0] h = '0;
         if (flush) begin
            mq.delete();
         end else begin
            if (auto_start && fl > 0) begin
               h = mq[0];
               if (int'(counter) >= int'(h[W-1:DW])) begin
                  is_late = int'(counter) > int'(h[W-1:DW]);
                  emit = !is_late || late_mode;
                  void'(mq.pop_front());
               end
            end
            if (write) begin
               if (fl >= FT) is_rej = 1'b1;
               else mq.push_back(fifo_din);
            end
         end
         m_cm <= emit;
         m_te <= is_late;
         m_oe <= is_rej;
         if (emit) m_rto <= h;
         if (is_late) m_ted <= h;
         if (is_rej) m_oed <= fifo_din;
         if (error_clear) m_tec <= '0;
         else if (is_late && m_tec != '1) m_tec <= m_tec + 1'b1;
         if (error_clear) m_oec <= '0;
         else if (is_rej && m_oec != '1) m_oec <= m_oec + 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("rto_out", rto_out, m_rto);
      chk("counter_matched", 32'(counter_matched), 32'(m_cm));
      chk("timestamp_error", 32'(timestamp_error), 32'(m_te));
      chk("timestamp_error_data", timestamp_error_data, m_ted);
      chk("overflow_error", 32'(overflow_error), 32'(m_oe));
      chk("overflow_error_data", overflow_error_data, m_oed);
      chk("ts_err_count", 32'(timestamp_error_count), 32'(m_tec));
      chk("ov_err_count", 32'(overflow_error_count), 32'(m_oec));
      chk("fill_level", 32'(fill_level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() >= FT));
      if (counter_matched) matched_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put(input logic [15:0] ts, input logic [15:0] d);
      write = 1'b1; fifo_din = {ts, d};
      @(negedge clk);
      write = 1'b0;
   endtask

   initial begin
      int m0;
      cyc(2);
      #1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_fill", 32'(fill_level), 32'd0);
      chk("rst_rto", rto_out, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // In-order release at exact timestamps
      auto_start = 1'b1; counter = 0;
      m0 = matched_seen;
      put(16'd10, 16'hA1); put(16'd20, 16'hA2); put(16'd30, 16'hA3);
      for (int c = 1; c <= 40; c++) begin
         counter = 16'(c);
         @(negedge clk);
      end
      #1;
      chk("release_rto", rto_out, 32'h001E_00A3);
      chk("release_empty", 32'(empty), 32'd1);
      chk("release_pulses", 32'(matched_seen - m0), 32'd3);

      // Late word, dropped then emitted
      counter = 16'd8; late_mode = 1'b0;
      put(16'd5, 16'hB1); cyc(2); #1;
      chk("late_drop_cnt", 32'(timestamp_error_count), 32'd1);
      chk("late_drop_data", timestamp_error_data, 32'h0005_00B1);
      chk("late_drop_rto", rto_out, 32'h001E_00A3);
      late_mode = 1'b1;
      put(16'd5, 16'hB2); cyc(2); #1;
      chk("late_emit_rto", rto_out, 32'h0005_00B2);
      chk("late_emit_cnt", 32'(timestamp_error_count), 32'd2);
      error_clear = 1'b1; cyc(1); error_clear = 1'b0; #1;
      chk("clr_ts_cnt", 32'(timestamp_error_count), 32'd0);

      // Overflow at threshold, then saturation of the 2-bit counter
      auto_start = 1'b0;
      for (int i = 1; i <= 14; i++) put(16'(100 + i), 16'(i));
      #1;
      chk("ovf_fill", 32'(fill_level), 32'd12);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_cnt", 32'(overflow_error_count), 32'd2);
      chk("ovf_data", overflow_error_data, 32'h0072_000E);
      for (int i = 15; i <= 17; i++) put(16'(100 + i), 16'(i));
      #1;
      chk("ovf_sat", 32'(overflow_error_count), 32'd3);
      error_clear = 1'b1; cyc(1); error_clear = 1'b0; #1;
      chk("ovf_clr", 32'(overflow_error_count), 32'd0);

      // Flush with a simultaneous write while full, then with 6 words queued
      flush = 1'b1; write = 1'b1; fifo_din = 32'hDEAD_BEEF;
      cyc(1); flush = 1'b0; write = 1'b0; #1;
      chk("flush_full_fill", 32'(fill_level), 32'd0);
      chk("flush_full_ovf", 32'(overflow_error_count), 32'd0);
      for (int i = 0; i < 6; i++) put(16'(500 + i), 16'(i));
      #1;
      chk("fill6", 32'(fill_level), 32'd6);
      flush = 1'b1; write = 1'b1; fifo_din = 32'h1234_5678;
      cyc(1); flush = 1'b0; write = 1'b0; #1;
      chk("flush_fill", 32'(fill_level), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_rto", rto_out, 32'h0005_00B2);

      // Push and pop in the same cycle
      auto_start = 1'b1; counter = 16'd200;
      put(16'd200, 16'hC1); put(16'd200, 16'hC2); put(16'd300, 16'hC3);
      cyc(1); #1;
      chk("pushpop_rto", rto_out, 32'h00C8_00C2);
      chk("pushpop_fill", 32'(fill_level), 32'd2 - 32'd1);

      // Async reset mid-stream
      auto_start = 1'b0; counter = 16'd400;
      for (int i = 0; i < 5; i++) put(16'd400, 16'(i));
      #1 reset_n = 1'b0;
      #1;
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_fill", 32'(fill_level), 32'd0);
      chk("arst_rto", rto_out, 32'd0);
      chk("arst_tsdata", timestamp_error_data, 32'd0);
      cyc(2);
      reset_n = 1'b1; auto_start = 1'b1;
      m0 = matched_seen;
      cyc(5); #1;
      chk("arst_no_pulse", 32'(matched_seen - m0), 32'd0);
      put(16'd400, 16'hD1); cyc(1); #1;
      chk("arst_new_rto", rto_out, 32'h0190_00D1);

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
